module_bin_bcd: RTL and testbench

MODULE_BIN_BCD -- requirements
Module: module_bin_bcd

---
 rtl/module_bin_bcd.sv | 113 +++++++++++
 tb/tb_module_bin_bcd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/module_bin_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3), IDLE/CONV/DONE.
// Optional macro BCD_SATURATE_EN: values above 9999 display as 9999 instead of value mod 10000.
module module_bin_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_input,
  input  logic        inicio,
  output logic [3:0]  unidades,
  output logic [3:0]  decenas,
  output logic [3:0]  centenas,
  output logic [3:0]  millares,
  output logic        listo,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd13;

  state_t      r_state;
  logic [13:0] r_shift;
  logic [19:0] r_acc;
  logic [3:0]  r_cnt;
`ifdef BCD_SATURATE_EN
  logic        r_over;
`endif

  logic [19:0] w_adj;

  // Add-3 correction on every BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    w_adj = r_acc;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
`ifdef BCD_SATURATE_EN
      r_over   <= 1'b0;
`endif
      unidades <= '0;
      decenas  <= '0;
      centenas <= '0;
      millares <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (inicio) begin
            r_shift <= bin_input;
            r_acc   <= '0;
            r_cnt   <= '0;
`ifdef BCD_SATURATE_EN
            r_over  <= (bin_input > 14'd9999);
`endif
            ocupado <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          {r_acc, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_ITER) begin
            ocupado <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
`ifdef BCD_SATURATE_EN
          if (r_over) begin
            unidades <= 4'd9;
            decenas  <= 4'd9;
            centenas <= 4'd9;
            millares <= 4'd9;
          end else begin
            unidades <= r_acc[3:0];
            decenas  <= r_acc[7:4];
            centenas <= r_acc[11:8];
            millares <= r_acc[15:12];
          end
`else
          // Ten-thousands nibble r_acc[19:16] is intentionally dropped.
          unidades <= r_acc[3:0];
          decenas  <= r_acc[7:4];
          centenas <= r_acc[11:8];
          millares <= r_acc[15:12];
`endif
          listo   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_bin_bcd.sv
// Self-checking bench for module_bin_bcd: cycle-level arithmetic model plus directed literal checks.
module tb_module_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] bin_input = '0;
  logic        inicio = 1'b0;
  logic [3:0]  unidades, decenas, centenas, millares;
  logic        listo, ocupado;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_listo = 0;
  int unsigned cyc = 0;

  module_bin_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .bin_input (bin_input),
    .inicio    (inicio),
    .unidades  (unidades),
    .decenas   (decenas),
    .centenas  (centenas),
    .millares  (millares),
    .listo     (listo),
    .ocupado   (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: age = cycles since the accepting edge, 0 when idle.
  int m_age = 0;
  int m_val = 0;
  int m_d[4] = '{0, 0, 0, 0};
  bit m_listo = 1'b0;
  bit m_ocup  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_age = 0; m_listo = 0; m_ocup = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
    end else begin
      m_listo = 0;
      if (m_age == 0) begin
        if (inicio) begin
          m_age = 1; m_val = int'(bin_input); m_ocup = 1;
        end
      end else if (m_age == 15) begin
        int v;
`ifdef BCD_SATURATE_EN
        v = (m_val > 9999) ? 9999 : m_val;
`else
        v = m_val % 10000;
`endif
        m_d[0] = v % 10; m_d[1] = (v / 10) % 10;
        m_d[2] = (v / 100) % 10; m_d[3] = (v / 1000) % 10;
        m_listo = 1; m_age = 0; m_ocup = 0;
      end else begin
        m_age++;
        m_ocup = (m_age <= 14);
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (listo) n_listo++;
    chk("listo", int'(listo), int'(m_listo));
    chk("ocupado", int'(ocupado), int'(m_ocup));
    chk("unidades", int'(unidades), m_d[0]);
    chk("decenas", int'(decenas), m_d[1]);
    chk("centenas", int'(centenas), m_d[2]);
    chk("millares", int'(millares), m_d[3]);
    chk("digit_range", int'(unidades <= 9 && decenas <= 9 && centenas <= 9 && millares <= 9), 1);
  end

  // Caller drives bin_input/inicio at a negedge; this waits for the accepting edge and the result.
  task automatic do_conv(output int lat, output int ocy);
    int t;
    bit got;
    @(posedge clk); #2;
    ocy = int'(ocupado);
    @(negedge clk); inicio = 1'b0;
    t = 0; got = 0;
    while (!got && t < 40) begin
      @(posedge clk); #2;
      t++;
      if (ocupado) ocy++;
      if (listo) got = 1;
    end
    lat = t;
    chk("listo_timeout", int'(got), 1);
    @(posedge clk); #2;
    chk("listo_width", int'(listo), 0);
  endtask

  task automatic chk_digits(input string tag, input int u, input int d, input int c, input int m);
    chk({tag, "_u"}, int'(unidades), u);
    chk({tag, "_d"}, int'(decenas), d);
    chk({tag, "_c"}, int'(centenas), c);
    chk({tag, "_m"}, int'(millares), m);
  endtask

  initial begin
    int lat, ocy, base, first, prev, npulse;
    repeat (3) @(negedge clk);
    chk_digits("reset", 0, 0, 0, 0);
    chk("reset_listo", int'(listo), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    rst = 1'b1;

    @(negedge clk); bin_input = 14'd0; inicio = 1'b1;
    do_conv(lat, ocy);
    chk("lat_zero", lat, 15);
    chk_digits("zero", 0, 0, 0, 0);

    @(negedge clk); bin_input = 14'd1234; inicio = 1'b1;
    do_conv(lat, ocy);
    chk("lat_1234", lat, 15);
    chk("ocupado_cycles", ocy, 14);
    chk_digits("v1234", 4, 3, 2, 1);

    @(negedge clk); bin_input = 14'd9999; inicio = 1'b1;
    do_conv(lat, ocy);
    chk_digits("v9999", 9, 9, 9, 9);
    @(negedge clk); bin_input = 14'd12345; inicio = 1'b1;
    do_conv(lat, ocy);
    chk("lat_12345", lat, 15);
`ifdef BCD_SATURATE_EN
    chk_digits("v12345", 9, 9, 9, 9);
`else
    chk_digits("v12345", 5, 4, 3, 2);
`endif

    // Request during CONV with changed input must be ignored.
    @(negedge clk); bin_input = 14'd42; inicio = 1'b1;
    base = int'(n_listo);
    @(posedge clk);
    @(negedge clk); inicio = 1'b0;
    repeat (4) @(negedge clk);
    bin_input = 14'd777; inicio = 1'b1;
    @(negedge clk); inicio = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignore_pulses", int'(n_listo) - base, 1);
    chk_digits("v42", 2, 4, 0, 0);

    // Reset in CONV cycle 7 aborts with cleared digits and no listo.
    @(negedge clk); bin_input = 14'd1234; inicio = 1'b1;
    @(posedge clk);
    @(negedge clk); inicio = 1'b0;
    repeat (6) @(negedge clk);
    base = int'(n_listo);
    rst = 1'b0;
    #1;
    chk_digits("abort", 0, 0, 0, 0);
    chk("abort_ocupado", int'(ocupado), 0);
    repeat (20) @(negedge clk);
    chk("abort_listo", int'(n_listo) - base, 0);
    rst = 1'b1; bin_input = 14'd56; inicio = 1'b1;
    do_conv(lat, ocy);
    chk("lat_56", lat, 15);
    chk_digits("v56", 6, 5, 0, 0);

    // Held request: one conversion every 16 cycles.
    @(negedge clk); bin_input = 14'd1; inicio = 1'b1;
    first = -1; prev = -1; npulse = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #2;
      if (listo) begin
        if (prev >= 0) chk("held_period", k - prev, 16);
        else first = k;
        prev = k; npulse++;
      end
    end
    chk("held_first", first, 15);
    chk("held_pulses", npulse, 4);
    chk_digits("v1", 1, 0, 0, 0);
    @(negedge clk); inicio = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      bin_input = 14'($urandom_range(0, 16383));
      inicio = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      else rst = 1'b1;
    end
    @(negedge clk); rst = 1'b1; inicio = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
